// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - shared barrier gate arbiter for one entry and one exit lane
// Round-robin lane grant, pass-sensor crossing detection, occupancy tracking and timeout/tailgate flags.
module parking_gate_arbiter #(
   parameter int CAPACITY = 8,
   parameter int CNT_W    = 4,
   parameter int TIMEOUT  = 50,
   parameter int TO_W     = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             entry_req,
   input  logic             exit_req,
   input  logic             pass_sensor,
   output logic             grant_entry,
   output logic             grant_exit,
   output logic             gate_open,
   output logic [CNT_W-1:0] occupancy,
   output logic             full,
   output logic             empty,
   output logic             timeout,
   output logic             tailgate
);

   typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, CLEAR} state_t;

   state_t          state;
   logic            last_exit;
   logic [TO_W-1:0] timer;
   logic            pass_prev;
   logic            ent_ok;
   logic            ext_ok;
   logic            pick_entry;

   assign full       = (occupancy == CNT_W'(CAPACITY));
   assign empty      = (occupancy == '0);
   assign ent_ok     = entry_req & ~full;
   assign ext_ok     = exit_req & ~empty;
   // Under contention the lane not served last time wins.
   assign pick_entry = ent_ok & (~ext_ok | last_exit);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         occupancy   <= '0;
         last_exit   <= 1'b1;
         timer       <= '0;
         pass_prev   <= 1'b0;
         grant_entry <= 1'b0;
         grant_exit  <= 1'b0;
         gate_open   <= 1'b0;
         timeout     <= 1'b0;
         tailgate    <= 1'b0;
      end else begin
         pass_prev <= pass_sensor;
         timeout   <= 1'b0;
         tailgate  <= 1'b0;
         case (state)
            IDLE: begin
               timer <= '0;
               if (pass_sensor && !pass_prev)
                  tailgate <= 1'b1;
               if (pick_entry) begin
                  state       <= OPEN_IN;
                  grant_entry <= 1'b1;
                  gate_open   <= 1'b1;
                  last_exit   <= 1'b0;
               end else if (ext_ok) begin
                  state      <= OPEN_OUT;
                  grant_exit <= 1'b1;
                  gate_open  <= 1'b1;
                  last_exit  <= 1'b1;
               end
            end
            OPEN_IN, OPEN_OUT: begin
               if (pass_sensor) begin
                  // Saturate so illegal sensor activity cannot wrap the count.
                  if (state == OPEN_IN && !full)
                     occupancy <= occupancy + 1'b1;
                  else if (state == OPEN_OUT && !empty)
                     occupancy <= occupancy - 1'b1;
                  state       <= CLEAR;
                  grant_entry <= 1'b0;
                  grant_exit  <= 1'b0;
                  gate_open   <= 1'b0;
               end else if (timer == TO_W'(TIMEOUT - 1)) begin
                  timeout     <= 1'b1;
                  state       <= CLEAR;
                  grant_entry <= 1'b0;
                  grant_exit  <= 1'b0;
                  gate_open   <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            CLEAR: begin
               if (!pass_sensor)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb/tb_parking_gate_arbiter.sv - self-checking bench for parking_gate_arbiter
module tb_parking_gate_arbiter;

   localparam int CAPACITY = 8;
   localparam int TIMEOUT  = 50;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       entry_req = 1'b0;
   logic       exit_req = 1'b0;
   logic       pass_sensor = 1'b0;
   logic       grant_entry, grant_exit, gate_open, full, empty, timeout, tailgate;
   logic [3:0] occupancy;

   parking_gate_arbiter #(.CAPACITY(CAPACITY), .CNT_W(4), .TIMEOUT(TIMEOUT), .TO_W(6)) dut (
      .clock(clock), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
      .pass_sensor(pass_sensor), .grant_entry(grant_entry), .grant_exit(grant_exit),
      .gate_open(gate_open), .occupancy(occupancy), .full(full), .empty(empty),
      .timeout(timeout), .tailgate(tailgate)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int passed = 0;

   // Reference model: who holds the gate, how long it has been open, how many cars are inside.
   int cars;
   int owner;          // 0 none, 1 entry lane, 2 exit lane
   bit clearing;
   bit exit_served_last;
   int open_cycles;
   bit prev_pass;
   bit exp_timeout;
   bit exp_tailgate;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic void model_reset();
      cars = 0; owner = 0; clearing = 0; exit_served_last = 1;
      open_cycles = 0; prev_pass = 0; exp_timeout = 0; exp_tailgate = 0;
   endfunction

   function automatic void model_step(input bit e, input bit x, input bit p);
      bit can_in, can_out;
      exp_timeout  = 0;
      exp_tailgate = 0;
      if (owner == 0 && !clearing) begin
         if (p && !prev_pass) exp_tailgate = 1;
         can_in  = e && (cars < CAPACITY);
         can_out = x && (cars > 0);
         if (can_in && (!can_out || exit_served_last)) begin
            owner = 1; exit_served_last = 0; open_cycles = 0;
         end else if (can_out) begin
            owner = 2; exit_served_last = 1; open_cycles = 0;
         end
      end else if (owner != 0) begin
         open_cycles++;
         if (p) begin
            if (owner == 1 && cars < CAPACITY) cars++;
            if (owner == 2 && cars > 0) cars--;
            owner = 0; clearing = 1;
         end else if (open_cycles == TIMEOUT) begin
            exp_timeout = 1; owner = 0; clearing = 1;
         end
      end else if (!p) begin
         clearing = 0;
      end
      prev_pass = p;
   endfunction

   task automatic compare_all();
      check("grant_entry", {7'd0, grant_entry}, {7'd0, owner == 1});
      check("grant_exit",  {7'd0, grant_exit},  {7'd0, owner == 2});
      check("gate_open",   {7'd0, gate_open},   {7'd0, owner != 0});
      check("occupancy",   {4'd0, occupancy},   8'(cars));
      check("full",        {7'd0, full},        {7'd0, cars == CAPACITY});
      check("empty",       {7'd0, empty},       {7'd0, cars == 0});
      check("timeout",     {7'd0, timeout},     {7'd0, exp_timeout});
      check("tailgate",    {7'd0, tailgate},    {7'd0, exp_tailgate});
   endtask

   // Called at a falling edge: drive, let the DUT clock, compare at the next falling edge.
   task automatic step(input bit e, input bit x, input bit p);
      entry_req = e; exit_req = x; pass_sensor = p;
      @(posedge clock);
      model_step(e, x, p);
      @(negedge clock);
      compare_all();
   endtask

   task automatic park_car(input bit from_entry);
      step(from_entry, !from_entry, 0);
      step(0, 0, 1);
      step(0, 0, 1);
      step(0, 0, 0);
   endtask

   initial begin
      int n;
      bit e, x, p;
      model_reset();
      repeat (2) @(negedge clock);
      compare_all();
      reset = 1'b0;

      // 1: single entry with a 3-cycle sensor pulse
      step(1, 0, 0);
      check("t1_grant_latency", {7'd0, grant_entry}, 8'd1);
      step(0, 0, 1);
      step(0, 0, 1);
      step(0, 0, 1);
      check("t1_occ", {4'd0, occupancy}, 8'd1);
      step(0, 0, 0);

      // 2: contention alternates, exit first because entry was served last
      step(1, 1, 0);
      check("t2_first_exit", {7'd0, grant_exit}, 8'd1);
      step(1, 1, 1);
      step(1, 1, 0);
      for (int i = 0; i < 6; i++) step(1, 1, (i % 3) == 1);

      // 3: fill to capacity, entry refused, exit then entry served
      while (cars < CAPACITY) park_car(1);
      check("t3_full", {7'd0, full}, 8'd1);
      step(1, 0, 0);
      check("t3_refused", {7'd0, grant_entry}, 8'd0);
      step(1, 1, 0);
      check("t3_exit_grant", {7'd0, grant_exit}, 8'd1);
      step(0, 0, 1);
      check("t3_occ7", {4'd0, occupancy}, 8'd7);
      step(0, 0, 0);
      step(1, 0, 0);
      check("t3_entry_grant", {7'd0, grant_entry}, 8'd1);
      step(0, 0, 1);
      step(0, 0, 0);

      // 4: empty park, exit ignored, entry times out after TIMEOUT cycles
      reset = 1'b1; model_reset();
      @(negedge clock); reset = 1'b0;
      step(0, 1, 0);
      check("t4_no_exit", {7'd0, grant_exit}, 8'd0);
      step(1, 0, 0);
      n = 0;
      for (int i = 1; i <= 60 && n == 0; i++) begin
         step(0, 0, 0);
         if (timeout) n = i;
      end
      check("t4_timeout_cycle", 8'(n), 8'(TIMEOUT));
      check("t4_occ", {4'd0, occupancy}, 8'd0);
      step(0, 0, 0);

      // 5: tailgate pulse in IDLE
      step(0, 0, 1);
      check("t5_tailgate", {7'd0, tailgate}, 8'd1);
      step(0, 0, 1);
      check("t5_pulse_width", {7'd0, tailgate}, 8'd0);
      step(0, 0, 0);

      // 6: async reset mid-grant
      park_car(1);
      step(1, 0, 0);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check("t6_gate_async", {7'd0, gate_open}, 8'd0);
      check("t6_occ_async", {4'd0, occupancy}, 8'd0);
      @(negedge clock); reset = 1'b0;
      entry_req = 0;

      // randomized traffic
      p = 0;
      for (int i = 0; i < 3000; i++) begin
         e = $urandom_range(0, 1);
         x = $urandom_range(0, 1);
         if ($urandom_range(0, 3) == 0) p = !p;
         step(e, x, p);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
